// File: rtl/ad7643_seq.sv
// ============================================================================
// ad7643_seq : AD7643 conversion sequencer (CNVST / BUSY wait / serial read).
// Optional 8-sample moving average when AD7643_SEQ_AVG8_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ad7643_seq #(
  parameter int PERIOD  = 250,
  parameter int CNVST_W = 4,
  parameter int NBITS   = 18,
  parameter int BUSY_TO = 200
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             run_i,
  input  logic             clr_flags_i,
  input  logic             adbusy_i,
  input  logic             adsdout_i,
  input  logic             dready_i,
  output logic             adcs_o,
  output logic             adcnvst_o,
  output logic             adsclk_o,
  output logic [NBITS-1:0] dout_o,
  output logic             dvalid_o,
  output logic             overrun_o,
  output logic             timeout_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CONV  = 3'd1,
    WAITB = 3'd2,
    SHIFT = 3'd3,
    GAP   = 3'd4
  } state_t;

  // Counter must survive a stretched period, not just PERIOD.
  localparam int CW = $clog2(PERIOD + CNVST_W + BUSY_TO + 2*NBITS + 2) + 1;
  localparam int SW = $clog2(CNVST_W + BUSY_TO + NBITS + 1) + 1;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [SW-1:0]    sub_q;
  logic             busy_seen_q;
  logic [NBITS-2:0] sh_q;
  logic             adcs_q, adcnvst_q, adsclk_q;
  logic [NBITS-1:0] dout_q;
  logic             dvalid_q, overrun_q, timeout_q;

  logic             busy_done, busy_tmo, shift_done;
  logic [NBITS-1:0] word_new, result;

  assign busy_done  = (state_q == WAITB) && busy_seen_q && !adbusy_i;
  assign busy_tmo   = (state_q == WAITB) && !busy_done && (sub_q == SW'(BUSY_TO - 1));
  assign shift_done = (state_q == SHIFT) && adsclk_q && (sub_q == SW'(NBITS - 1));
  assign word_new   = {sh_q, adsdout_i};

`ifdef AD7643_SEQ_AVG8_EN
  logic [NBITS-1:0] hist_q [8];
  logic [NBITS+2:0] sum_q, sum_d;

  assign sum_d  = sum_q - {3'b000, hist_q[7]} + {3'b000, word_new};
  assign result = sum_d[NBITS+2:3];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q <= '0;
      for (int i = 0; i < 8; i++) hist_q[i] <= '0;
    end else if (shift_done) begin
      sum_q     <= sum_d;
      hist_q[0] <= word_new;
      for (int i = 1; i < 8; i++) hist_q[i] <= hist_q[i-1];
    end
  end
`else
  assign result = word_new;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sub_q       <= '0;
      busy_seen_q <= 1'b0;
      sh_q        <= '0;
      adcs_q      <= 1'b1;
      adcnvst_q   <= 1'b0;
      adsclk_q    <= 1'b0;
      dout_q      <= '0;
      dvalid_q    <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      if (state_q != IDLE) cnt_q <= cnt_q + CW'(1);
      case (state_q)
        IDLE: begin
          if (run_i) begin
            state_q   <= CONV;
            cnt_q     <= '0;
            sub_q     <= '0;
            adcnvst_q <= 1'b1;
          end
        end
        CONV: begin
          sub_q <= sub_q + SW'(1);
          if (sub_q == SW'(CNVST_W - 1)) begin
            state_q     <= WAITB;
            sub_q       <= '0;
            adcnvst_q   <= 1'b0;
            adcs_q      <= 1'b0;
            busy_seen_q <= 1'b0;
          end
        end
        WAITB: begin
          sub_q <= sub_q + SW'(1);
          if (adbusy_i) busy_seen_q <= 1'b1;
          if (busy_done) begin
            state_q  <= SHIFT;
            sub_q    <= '0;
            adsclk_q <= 1'b0;
          end else if (busy_tmo) begin
            state_q <= GAP;
            adcs_q  <= 1'b1;
          end
        end
        SHIFT: begin
          adsclk_q <= ~adsclk_q;
          // The ADC bit is taken on the edge that drops SCLK.
          if (adsclk_q) begin
            sh_q  <= word_new[NBITS-2:0];
            sub_q <= sub_q + SW'(1);
          end
          if (shift_done) begin
            state_q  <= GAP;
            adsclk_q <= 1'b0;
            adcs_q   <= 1'b1;
          end
        end
        GAP: begin
          if (cnt_q >= CW'(PERIOD - 1)) begin
            cnt_q <= '0;
            sub_q <= '0;
            if (run_i) begin
              state_q   <= CONV;
              adcnvst_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase

      if (shift_done) begin
        dout_q   <= result;
        dvalid_q <= 1'b1;
      end else if (dvalid_q && dready_i) begin
        dvalid_q <= 1'b0;
      end

      if (shift_done && dvalid_q && !dready_i) overrun_q <= 1'b1;
      else if (clr_flags_i)                   overrun_q <= 1'b0;

      if (busy_tmo)         timeout_q <= 1'b1;
      else if (clr_flags_i) timeout_q <= 1'b0;
    end
  end

  assign adcs_o    = adcs_q;
  assign adcnvst_o = adcnvst_q;
  assign adsclk_o  = adsclk_q;
  assign dout_o    = dout_q;
  assign dvalid_o  = dvalid_q;
  assign overrun_o = overrun_q;
  assign timeout_o = timeout_q;
  assign state_o   = state_q;

endmodule

`default_nettype wire
